// File: rtl/vend_pkg.sv
// Shared state encoding, default parameter constants and a width helper
// for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_VEND,
    ST_ERR
  } vend_state_e;

  localparam int unsigned DEF_NUM_COINS  = 2;
  localparam int unsigned DEF_NUM_PROD   = 2;
  localparam int unsigned DEF_CRED_W     = 4;
  localparam logic [7:0]  DEF_PRICES     = {4'd3, 4'd2};
  localparam int unsigned DEF_MAX_CREDIT = 9;
  localparam int unsigned DEF_TICK_DIV   = 262144;
  localparam int unsigned DEF_DB_TICKS   = 3;
  localparam int unsigned DEF_ERR_HOLD   = 8;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_conditioner.sv
// Synchronises one raw button, debounces it on the shared sample tick and
// emits a single-cycle pulse on each stable press.
module input_conditioner
  import vend_pkg::*;
#(
  parameter int unsigned DB_TICKS = DEF_DB_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic event_o
);

  localparam int unsigned CW = clog2_min1(DB_TICKS + 1);

  logic          sync1_q, sync2_q;
  logic          samp_q, samp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          armed_q, armed_d;
  logic          event_q, event_d;

  always_comb begin
    samp_d   = samp_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    armed_d  = armed_q;
    if (tick) begin
      if (sync2_q != samp_q) begin
        samp_d = sync2_q;
        cnt_d  = CW'(1);
      end else if (cnt_q < CW'(DB_TICKS)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Presses only count once a released level has been confirmed, so a
    // button held through reset stays silent until pressed again.
    if (cnt_q == CW'(DB_TICKS)) begin
      stable_d = samp_q;
      if (!samp_q) armed_d = 1'b1;
    end
    event_d = armed_q & stable_d & ~stable_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      samp_q   <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      armed_q  <= 1'b0;
      event_q  <= 1'b0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      armed_q  <= armed_d;
      event_q  <= event_d;
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/vending_ctrl.sv
// Coin-operated vending controller: debounced buttons feed a credit/vend/
// refund FSM whose outputs are all registered one cycle after the event.
module vending_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned                 NUM_COINS  = DEF_NUM_COINS,
  parameter int unsigned                 NUM_PROD   = DEF_NUM_PROD,
  parameter int unsigned                 CRED_W     = DEF_CRED_W,
  parameter logic [NUM_PROD*CRED_W-1:0]  PRICES     = DEF_PRICES,
  parameter int unsigned                 MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int unsigned                 TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned                 DB_TICKS   = DEF_DB_TICKS,
  parameter int unsigned                 ERR_HOLD   = DEF_ERR_HOLD
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_COINS-1:0]              coin,
  input  logic                              enter,
  input  logic                              cancel,
  input  logic [clog2_min1(NUM_PROD)-1:0]   sel,
  output logic [NUM_PROD-1:0]               release_o,
  output logic [CRED_W-1:0]                 change,
  output logic                              change_valid,
  output logic                              coin_reject,
  output logic                              error,
  output logic [CRED_W-1:0]                 credit
);

  localparam int unsigned SW  = clog2_min1(NUM_PROD);
  localparam int unsigned TW  = clog2_min1(TICK_DIV);
  localparam int unsigned ECW = clog2_min1(ERR_HOLD);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_cnt_q <= '0;
    else      tick_cnt_q <= tick_cnt_d;
  end

  logic [NUM_COINS-1:0] coin_ev;
  logic                 enter_ev, cancel_ev;

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_coin
    input_conditioner #(.DB_TICKS(DB_TICKS)) u_cond (
      .clk(clk), .rst_n(rst), .tick(tick), .din(coin[g]), .event_o(coin_ev[g])
    );
  end

  input_conditioner #(.DB_TICKS(DB_TICKS)) u_enter (
    .clk(clk), .rst_n(rst), .tick(tick), .din(enter), .event_o(enter_ev)
  );

  input_conditioner #(.DB_TICKS(DB_TICKS)) u_cancel (
    .clk(clk), .rst_n(rst), .tick(tick), .din(cancel), .event_o(cancel_ev)
  );

  vend_state_e         state_q, state_d;
  logic [CRED_W-1:0]   credit_q, credit_d;
  logic [CRED_W-1:0]   change_q, change_d;
  logic [NUM_PROD-1:0] rel_q, rel_d;
  logic                cv_q, cv_d;
  logic                rej_q, rej_d;
  logic                err_q, err_d;
  logic [ECW-1:0]      err_cnt_q, err_cnt_d;

  logic                coin_found;
  int unsigned         coin_val;
  logic                coin_multi;
  logic                sel_ok;
  logic [SW-1:0]       sel_idx;
  int unsigned         price_base;
  logic [CRED_W-1:0]   price;
  logic [CRED_W:0]     sum;

  always_comb begin
    coin_found = 1'b0;
    coin_val   = 0;
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      if (coin_ev[i] && !coin_found) begin
        coin_found = 1'b1;
        coin_val   = i + 1;
      end
    end
    coin_multi = (coin_ev & (coin_ev - 1'b1)) != '0;
    sel_ok     = (32'(sel) < NUM_PROD);
    sel_idx    = sel_ok ? sel : '0;
    price_base = 32'(sel_idx) * CRED_W;
    price      = PRICES[price_base +: CRED_W];
    sum        = {1'b0, credit_q} + (CRED_W + 1)'(coin_val);

    state_d   = state_q;
    credit_d  = credit_q;
    change_d  = change_q;
    rel_d     = '0;
    cv_d      = 1'b0;
    rej_d     = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        // Cancel beats enter beats coin; losers are dropped without reject.
        if (cancel_ev) begin
          if (credit_q != '0) begin
            change_d = credit_q;
            cv_d     = 1'b1;
            credit_d = '0;
            state_d  = ST_IDLE;
          end
        end else if (enter_ev) begin
          if (sel_ok && credit_q >= price) begin
            rel_d    = NUM_PROD'(1) << sel_idx;
            change_d = credit_q - price;
            cv_d     = 1'b1;
            credit_d = '0;
            state_d  = ST_VEND;
          end else begin
            err_d     = 1'b1;
            err_cnt_d = ECW'(ERR_HOLD - 1);
            state_d   = ST_ERR;
          end
        end else if (coin_found) begin
          if (sum <= (CRED_W + 1)'(MAX_CREDIT)) begin
            credit_d = sum[CRED_W-1:0];
            state_d  = ST_CREDIT;
          end else begin
            rej_d = 1'b1;
          end
          if (coin_multi) rej_d = 1'b1;
        end
      end
      ST_VEND: begin
        rej_d   = |coin_ev;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        rej_d = |coin_ev;
        if (err_cnt_q == '0) begin
          state_d = (credit_q == '0) ? ST_IDLE : ST_CREDIT;
        end else begin
          err_d     = 1'b1;
          err_cnt_d = err_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      credit_q  <= '0;
      change_q  <= '0;
      rel_q     <= '0;
      cv_q      <= 1'b0;
      rej_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      change_q  <= change_d;
      rel_q     <= rel_d;
      cv_q      <= cv_d;
      rej_q     <= rej_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign release_o    = rel_q;
  assign change       = change_q;
  assign change_valid = cv_q;
  assign coin_reject  = rej_q;
  assign error        = err_q;
  assign credit       = credit_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench for vending_ctrl with a fast debounce tick; output pulses
// are tallied by a monitor and compared against hand-computed deltas.
module tb_vending_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin = '0;
  logic       enter = 1'b0;
  logic       cancel = 1'b0;
  logic [0:0] sel = '0;
  logic [1:0] release_o;
  logic [3:0] change;
  logic       change_valid;
  logic       coin_reject;
  logic       error;
  logic [3:0] credit;

  vending_ctrl #(
    .TICK_DIV(4),
    .DB_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .coin(coin), .enter(enter), .cancel(cancel),
    .sel(sel), .release_o(release_o), .change(change),
    .change_valid(change_valid), .coin_reject(coin_reject),
    .error(error), .credit(credit)
  );

  always #5 clk = ~clk;

  int rel_n = 0, cv_n = 0, rej_n = 0, err_n = 0;
  int last_rel = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (release_o != '0) begin
        rel_n++;
        last_rel = int'(release_o);
      end
      if (change_valid) cv_n++;
      if (coin_reject)  rej_n++;
      if (error)        err_n++;
    end
  end

  int vecs = 0, miscompares = 0;
  int rel_s, cv_s, rej_s, err_s;

  task automatic check(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    rel_s = rel_n; cv_s = cv_n; rej_s = rej_n; err_s = err_n;
  endtask

  task automatic press(input logic [1:0] c, input logic e, input logic k);
    coin = c; enter = e; cancel = k;
    repeat (24) @(negedge clk);
    coin = '0; enter = 1'b0; cancel = 1'b0;
    repeat (24) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_credit", int'(credit), 0);
    check("rst_change", int'(change), 0);
    check("rst_release", int'(release_o), 0);
    check("rst_cv", int'(change_valid), 0);
    check("rst_reject", int'(coin_reject), 0);
    check("rst_error", int'(error), 0);
    rst = 1'b1;
    repeat (30) @(negedge clk);

    // Coin worth 2, buy product 0 (price 2)
    press(2'b10, 1'b0, 1'b0);
    check("c1_credit", int'(credit), 2);
    snap(); sel = 1'b0;
    press(2'b00, 1'b1, 1'b0);
    check("buy0_rel_n", rel_n - rel_s, 1);
    check("buy0_rel", last_rel, 1);
    check("buy0_change", int'(change), 0);
    check("buy0_cv_n", cv_n - cv_s, 1);
    check("buy0_credit", int'(credit), 0);

    // Three coins worth 1, buy product 1 (price 3)
    for (int i = 0; i < 3; i++) press(2'b01, 1'b0, 1'b0);
    check("c0x3_credit", int'(credit), 3);
    snap(); sel = 1'b1;
    press(2'b00, 1'b1, 1'b0);
    check("buy1_rel_n", rel_n - rel_s, 1);
    check("buy1_rel", last_rel, 2);
    check("buy1_change", int'(change), 0);
    check("buy1_credit", int'(credit), 0);

    // Insufficient credit: error for 8 cycles, credit retained
    press(2'b10, 1'b0, 1'b0);
    snap();
    press(2'b00, 1'b1, 1'b0);
    check("err_cycles", err_n - err_s, 8);
    check("err_rel_n", rel_n - rel_s, 0);
    check("err_cv_n", cv_n - cv_s, 0);
    check("err_credit", int'(credit), 2);
    press(2'b00, 1'b0, 1'b1);
    check("refund2_change", int'(change), 2);
    check("refund2_credit", int'(credit), 0);

    // Fill to MAX_CREDIT, next coin rejected
    for (int i = 0; i < 4; i++) press(2'b10, 1'b0, 1'b0);
    check("fill8_credit", int'(credit), 8);
    snap();
    press(2'b01, 1'b0, 1'b0);
    check("fill9_credit", int'(credit), 9);
    check("fill9_rej_n", rej_n - rej_s, 0);
    snap();
    press(2'b01, 1'b0, 1'b0);
    check("over_rej_n", rej_n - rej_s, 1);
    check("over_credit", int'(credit), 9);
    snap();
    press(2'b00, 1'b0, 1'b1);
    check("refund9_change", int'(change), 9);
    check("refund9_cv_n", cv_n - cv_s, 1);

    // Bouncing coin then stable press: single increment
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      coin[0] = ~coin[0];
    end
    press(2'b01, 1'b0, 1'b0);
    check("bounce_credit", int'(credit), 1);
    press(2'b00, 1'b0, 1'b1);
    check("refund1_change", int'(change), 1);

    // Cancel and enter together: cancel wins
    press(2'b10, 1'b0, 1'b0);
    snap(); sel = 1'b0;
    press(2'b00, 1'b1, 1'b1);
    check("ce_change", int'(change), 2);
    check("ce_cv_n", cv_n - cv_s, 1);
    check("ce_rel_n", rel_n - rel_s, 0);
    check("ce_err_n", err_n - err_s, 0);
    check("ce_credit", int'(credit), 0);

    // Two coins in one cycle: lowest index accepted, other rejected
    snap();
    press(2'b11, 1'b0, 1'b0);
    check("dual_credit", int'(credit), 1);
    check("dual_rej_n", rej_n - rej_s, 1);

    // Reset during ERR, enter held through reset
    sel = 1'b1;
    enter = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (error) break;
      @(negedge clk);
    end
    check("err_seen", int'(error), 1);
    rst = 1'b0;
    #1;
    check("rstErr_error", int'(error), 0);
    check("rstErr_credit", int'(credit), 0);
    check("rstErr_change", int'(change), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    snap();
    repeat (24) @(negedge clk);
    enter = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("held_err_n", err_n - err_s, 0);
    check("held_rel_n", rel_n - rel_s, 0);
    check("held_credit", int'(credit), 0);
    press(2'b10, 1'b0, 1'b0);
    check("postrst_credit", int'(credit), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/vending_ctrl.md
VENDING_CTRL -- requirements
Module: vending_ctrl

Interface
REQ-001 SHALL have parameter NUM_COINS, default 2: number of coin inputs; coin i is worth i+1 credit units.
REQ-002 SHALL have parameter NUM_PROD, default 2: number of products.
REQ-003 SHALL have parameter CRED_W, default 4: credit/price/change width.
REQ-004 SHALL have parameter PRICES, default {4'd3,4'd2}: packed NUM_PROD*CRED_W price table; product p uses slice p.
REQ-005 SHALL have parameter MAX_CREDIT, default 9: highest credit accepted.
REQ-006 SHALL have parameter TICK_DIV, default 262144: clk cycles per debounce sample tick.
REQ-007 SHALL have parameter DB_TICKS, default 3: consecutive equal samples that make an input stable.
REQ-008 SHALL have parameter ERR_HOLD, default 8: clk cycles error stays high.
REQ-009 clk  input  1  system clock, the only clock.
REQ-010 rst  input  1  asynchronous, active-low reset.
REQ-011 coin  input  NUM_COINS  raw, bouncing coin buttons.
REQ-012 enter  input  1  raw purchase button.
REQ-013 cancel  input  1  raw refund button.
REQ-014 sel  input  $clog2(NUM_PROD) (min 1)  product select, sampled on the enter event.
REQ-015 release  output  NUM_PROD  one-hot, one-cycle product release pulse.
REQ-016 change  output  CRED_W  change value, valid with change_valid.
REQ-017 change_valid  output  1  one-cycle change/refund pulse.
REQ-018 coin_reject  output  1  one-cycle pulse: coin event discarded.
REQ-019 error  output  1  failed purchase indication.
REQ-020 credit  output  CRED_W  current accumulated credit.

Function
REQ-021 Every raw input SHALL pass a 2-flop synchroniser, be sampled on each tick, and count as stable after DB_TICKS equal samples.
REQ-022 A 0->1 stable transition SHALL yield exactly one one-cycle event pulse in clk domain; holding a button SHALL give no further events.
REQ-023 The tick SHALL come from a free-running counter, wrapping 0..TICK_DIV-1, one-cycle tick at wrap; all logic runs on clk (no derived clocks).
REQ-024 FSM states SHALL be IDLE (credit 0), CREDIT, VEND, ERR.
REQ-025 Same-cycle priority SHALL be cancel > enter > coin; lower-priority events that cycle are dropped (no coin_reject for drops by priority).
REQ-026 Several coin events in one cycle: lowest index accepted, others dropped with coin_reject.
REQ-027 Coin event in IDLE/CREDIT: if credit+value <= MAX_CREDIT, credit updates next cycle and state = CREDIT; else credit unchanged, coin_reject next cycle.
REQ-028 Enter event with sel < NUM_PROD and credit >= price: next cycle release[sel]=1, change=credit-price, change_valid=1 (even if change 0), credit=0; state VEND for that one cycle, then IDLE.
REQ-029 Enter event with credit < price or sel >= NUM_PROD: state ERR, error high exactly ERR_HOLD cycles starting next cycle, credit retained, then return to CREDIT (IDLE if credit 0).
REQ-030 Cancel event with credit > 0: next cycle change=credit, change_valid=1, credit=0, state IDLE; with credit 0: no outputs.
REQ-031 Events arriving during VEND or ERR SHALL be ignored, including coins (coin_reject pulses).
REQ-032 Event-to-output latency SHALL be exactly one clk cycle; all outputs registered.
REQ-033 change SHALL hold its last value between change_valid pulses.

Reset
REQ-034 rst low SHALL asynchronously force: state IDLE, credit 0, change 0, release 0, change_valid 0, coin_reject 0, error 0, tick and debounce counters 0, debounced levels 0.
REQ-035 Reset mid-VEND/ERR SHALL abort with no pulse after release; a button held through reset SHALL produce no event until released and pressed again.

Structure
REQ-036 Shared package vend_pkg SHALL hold the state encoding and default parameter constants.
REQ-037 Sub-module input_conditioner (sync + debounce + edge) SHALL be instantiated once per raw input, sharing the single tick.

Verification (TICK_DIV=4, DB_TICKS=3, defaults otherwise)
REQ-038 coin[1] press, enter sel=0 -> release=01, change=0, change_valid, credit 0.
REQ-039 coin[0] x3, enter sel=1 -> release=10, change=0; then coin[1], enter sel=1 -> error 8 cycles, credit stays 2.
REQ-040 coin[1] x4 then coin[0] x2 -> credit 8, then 9, second coin[0] coin_reject, credit 9.
REQ-041 Bouncing coin[0] (toggle each clk, 10 clk) then stable high -> exactly one credit increment.
REQ-042 coin[1] then cancel and enter in same cycle -> change=2 refund, no release, no error.
REQ-043 rst low during ERR -> error 0 immediately, credit 0, IDLE after release.
